// File: rtl/dram_req_queue.sv
// Request FIFO plus single-outstanding issue engine in front of a DRAM controller.
// Reads return their data in request order through a one-cycle response strobe.
module dram_req_queue #(
    parameter int U_ADDR_WIDTH = 12,
    parameter int U_DATA_WIDTH = 8,
    parameter int DEPTH        = 4
) (
    input  logic                    u_clk,
    input  logic                    u_rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_cmd,
    input  logic [U_ADDR_WIDTH-1:0] req_addr,
    input  logic [U_DATA_WIDTH-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [U_DATA_WIDTH-1:0] rsp_data,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    u_en,
    output logic                    u_cmd,
    output logic [U_ADDR_WIDTH-1:0] u_addr,
    output logic [U_DATA_WIDTH-1:0] u_data_i,
    input  logic [U_DATA_WIDTH-1:0] u_data_o,
    input  logic                    u_data_valid,
    input  logic                    u_cmd_ack,
    input  logic                    u_busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA
    } state_t;

    state_t                  state;
    logic                    mem_cmd  [DEPTH];
    logic [U_ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [U_DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic                    push;
    logic                    pop;

    assign req_ready = (occupancy < OW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (state == ISSUE) && u_cmd_ack;

    // Entry storage; only written on an accepted push, so a full-queue push is harmless.
    always_ff @(posedge u_clk) begin
        if (push) begin
            mem_cmd[wr_ptr]  <= req_cmd;
            mem_addr[wr_ptr] <= req_addr;
            mem_data[wr_ptr] <= req_wdata;
        end
    end

    // Head/tail pointers wrap naturally (power-of-two depth); count tracks push minus pop.
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Issue FSM: present head entry, hold until ack, then collect read data if needed.
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state     <= IDLE;
            u_en      <= 1'b0;
            u_cmd     <= 1'b0;
            u_addr    <= '0;
            u_data_i  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if ((occupancy != '0) && !u_busy) begin
                        u_en     <= 1'b1;
                        u_cmd    <= mem_cmd[rd_ptr];
                        u_addr   <= mem_addr[rd_ptr];
                        u_data_i <= mem_data[rd_ptr];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (u_cmd_ack) begin
                        u_en <= 1'b0;
                        if (u_cmd) begin
                            state <= IDLE;
                        end else if (u_data_valid) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= u_data_o;
                            state     <= IDLE;
                        end else begin
                            state <= WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (u_data_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= u_data_o;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_req_queue.sv
// Directed bench for dram_req_queue with a queue-based reference model
// checked every falling edge, plus literal expectations per scenario.
module tb_dram_req_queue;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          u_clk = 1'b0;
    logic          u_rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_cmd = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic [2:0]    occupancy;
    logic          u_en;
    logic          u_cmd;
    logic [AW-1:0] u_addr;
    logic [DW-1:0] u_data_i;
    logic [DW-1:0] u_data_o = '0;
    logic          u_data_valid = 1'b0;
    logic          u_cmd_ack = 1'b0;
    logic          u_busy = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    dram_req_queue #(
        .U_ADDR_WIDTH(AW),
        .U_DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .u_clk(u_clk),
        .u_rst_n(u_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd(req_cmd),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .occupancy(occupancy),
        .u_en(u_en),
        .u_cmd(u_cmd),
        .u_addr(u_addr),
        .u_data_i(u_data_i),
        .u_data_o(u_data_o),
        .u_data_valid(u_data_valid),
        .u_cmd_ack(u_cmd_ack),
        .u_busy(u_busy)
    );

    always #5 u_clk = ~u_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {cmd, addr, wdata} and the command presented to the controller.
    logic [20:0] q[$];
    logic        m_en = 1'b0;
    logic        m_inf = 1'b0;
    logic        m_rv = 1'b0;
    logic [DW-1:0] m_rd = '0;
    logic [20:0] m_head = '0;

    always @(negedge u_clk) begin
        logic do_push;
        if (!u_rst_n) begin
            q.delete();
            m_en = 1'b0;
            m_inf = 1'b0;
            m_rv = 1'b0;
            check("rst_cmd", {31'd0, u_cmd}, 0);
            check("rst_addr", {20'd0, u_addr}, 0);
            check("rst_data_i", {24'd0, u_data_i}, 0);
            check("rst_rsp_data", {24'd0, rsp_data}, 0);
        end
        check("occupancy", {29'd0, occupancy}, q.size());
        check("req_ready", {31'd0, req_ready}, {31'd0, q.size() < DEPTH});
        check("u_en", {31'd0, u_en}, {31'd0, m_en});
        if (m_en) begin
            check("u_cmd", {31'd0, u_cmd}, {31'd0, m_head[20]});
            check("u_addr", {20'd0, u_addr}, {20'd0, m_head[19:8]});
            check("u_data_i", {24'd0, u_data_i}, {24'd0, m_head[7:0]});
        end
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
        if (m_rv) check("rsp_data", {24'd0, rsp_data}, {24'd0, m_rd});
        if (u_rst_n) begin
            do_push = req_valid && (q.size() < DEPTH);
            m_rv = 1'b0;
            if (m_en) begin
                if (u_cmd_ack) begin
                    void'(q.pop_front());
                    m_en = 1'b0;
                    if (!m_head[20]) begin
                        if (u_data_valid) begin
                            m_rv = 1'b1;
                            m_rd = u_data_o;
                        end else begin
                            m_inf = 1'b1;
                        end
                    end
                end
            end else if (m_inf) begin
                if (u_data_valid) begin
                    m_rv = 1'b1;
                    m_rd = u_data_o;
                    m_inf = 1'b0;
                end
            end else if (q.size() > 0 && !u_busy) begin
                m_en = 1'b1;
                m_head = q[0];
            end
            if (do_push) q.push_back({req_cmd, req_addr, req_wdata});
        end
    end

    task automatic cyc();
        @(posedge u_clk);
        #1;
    endtask

    task automatic push(input logic c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_cmd = c;
        req_addr = a;
        req_wdata = d;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_en();
        int k;
        k = 0;
        while (!u_en && k < 50) begin
            cyc();
            k++;
        end
        if (!u_en) check("wait_en_timeout", 0, 1);
    endtask

    task automatic ack_once();
        u_cmd_ack = 1'b1;
        cyc();
        u_cmd_ack = 1'b0;
    endtask

    initial begin
        int en_seen;
        cyc();
        cyc();
        u_rst_n = 1'b1;
        check("ready_after_reset", {31'd0, req_ready}, 1);
        check("occ_after_reset", {29'd0, occupancy}, 0);
        cyc();

        // Single write, ack in the third u_en cycle
        push(1'b1, 12'h2A5, 8'h3C);
        wait_en();
        check("wr_addr", {20'd0, u_addr}, 32'h2A5);
        check("wr_data", {24'd0, u_data_i}, 32'h3C);
        check("wr_occ", {29'd0, occupancy}, 1);
        cyc();
        check("wr_en_hold2", {31'd0, u_en}, 1);
        cyc();
        check("wr_en_hold3", {31'd0, u_en}, 1);
        ack_once();
        check("wr_en_drop", {31'd0, u_en}, 0);
        check("wr_occ_end", {29'd0, occupancy}, 0);
        cyc();

        // Single read, data five cycles after the ack
        push(1'b0, 12'h155, 8'h00);
        wait_en();
        check("rd_cmd", {31'd0, u_cmd}, 0);
        ack_once();
        repeat (4) cyc();
        u_data_o = 8'hA7;
        u_data_valid = 1'b1;
        cyc();
        u_data_valid = 1'b0;
        check("rd_rsp_valid", {31'd0, rsp_valid}, 1);
        check("rd_rsp_data", {24'd0, rsp_data}, 32'hA7);
        cyc();
        check("rd_rsp_pulse", {31'd0, rsp_valid}, 0);
        cyc();

        // Full FIFO: five pushes with no ack, fifth dropped
        req_valid = 1'b1;
        req_cmd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_addr = 12'h101 + 12'(i);
            req_wdata = 8'h10 + 8'(i);
            cyc();
        end
        req_valid = 1'b0;
        check("full_occ", {29'd0, occupancy}, 4);
        check("full_ready", {31'd0, req_ready}, 0);
        for (int i = 0; i < 4; i++) begin
            wait_en();
            check("drain_addr", {20'd0, u_addr}, 32'h101 + i);
            ack_once();
        end
        check("drain_occ", {29'd0, occupancy}, 0);
        push(1'b1, 12'h1A0, 8'h55);
        push(1'b1, 12'h1A1, 8'h66);
        for (int i = 0; i < 2; i++) begin
            wait_en();
            check("wrap_addr", {20'd0, u_addr}, 32'h1A0 + i);
            ack_once();
        end
        cyc();

        // Busy gating for 20 cycles with two entries queued
        u_busy = 1'b1;
        push(1'b1, 12'h0C0, 8'h01);
        push(1'b1, 12'h0C1, 8'h02);
        en_seen = 0;
        repeat (20) begin
            if (u_en) en_seen++;
            cyc();
        end
        check("busy_no_en", en_seen, 0);
        u_busy = 1'b0;
        cyc();
        check("busy_release_en", {31'd0, u_en}, 1);
        check("busy_release_addr", {20'd0, u_addr}, 32'h0C0);
        ack_once();
        wait_en();
        ack_once();
        cyc();

        // Reset while waiting for read data
        push(1'b0, 12'h077, 8'h00);
        wait_en();
        ack_once();
        cyc();
        u_rst_n = 1'b0;
        cyc();
        cyc();
        u_rst_n = 1'b1;
        check("mid_rst_ready", {31'd0, req_ready}, 1);
        check("mid_rst_occ", {29'd0, occupancy}, 0);
        u_data_o = 8'hEE;
        u_data_valid = 1'b1;
        cyc();
        u_data_valid = 1'b0;
        check("mid_rst_no_rsp", {31'd0, rsp_valid}, 0);
        cyc();

        // Same-cycle ack and data on a read, write queued behind it
        push(1'b0, 12'h0AA, 8'h00);
        push(1'b1, 12'h0BB, 8'h77);
        wait_en();
        check("same_rd_addr", {20'd0, u_addr}, 32'h0AA);
        u_data_o = 8'h5E;
        u_data_valid = 1'b1;
        ack_once();
        u_data_valid = 1'b0;
        check("same_rsp_valid", {31'd0, rsp_valid}, 1);
        check("same_rsp_data", {24'd0, rsp_data}, 32'h5E);
        check("same_gap", {31'd0, u_en}, 0);
        cyc();
        check("same_next_en", {31'd0, u_en}, 1);
        check("same_next_addr", {20'd0, u_addr}, 32'h0BB);
        check("same_rsp_pulse", {31'd0, rsp_valid}, 0);
        ack_once();
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
